// File: rtl/fifo_tx_arbiter_if.sv
// Handshake bundle between producers, the tx arbiter and the fifo tx port.
// master = arbiter side, slave = producers/fifo side.
interface fifo_tx_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_rdy;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_done;
  logic                  fifo_tx_rdy;
  logic [WIDTH-1:0]      fifo_in_data;
  logic                  fifo_tx_done;
  logic                  fifo_full;
  logic [IDW-1:0]        grant_id;
  logic                  busy;

  modport master (
    input  req_rdy,
    input  req_data,
    input  fifo_tx_done,
    input  fifo_full,
    output req_done,
    output fifo_tx_rdy,
    output fifo_in_data,
    output grant_id,
    output busy
  );

  modport slave (
    output req_rdy,
    output req_data,
    output fifo_tx_done,
    output fifo_full,
    input  req_done,
    input  fifo_tx_rdy,
    input  fifo_in_data,
    input  grant_id,
    input  busy
  );
endinterface

// File: rtl/fifo_tx_arbiter.sv
// Round-robin arbiter sharing one fifo tx port among NREQ producers.
// Four-phase rdy/done handshake on both sides; all outputs registered.
module fifo_tx_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  fifo_tx_arbiter_if.master bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    ACK,
    RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gnt_q, gnt_d;
  logic             tx_q, tx_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q, busy_d;
  logic [IDW-1:0]   pick;
  logic             found;

  // first requester searching upward from the slot after the last grant
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && bus.req_rdy[(int'(ptr_q) + i) % NREQ]) begin
        found = 1'b1;
        pick  = IDW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  // next-state and next-output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    tx_d    = tx_q;
    dat_d   = dat_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        if (found && !bus.fifo_full) begin
          gnt_d   = pick;
          dat_d   = bus.req_data[int'(pick)*WIDTH +: WIDTH];
          tx_d    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.fifo_tx_done) begin
          tx_d          = 1'b0;
          done_d        = '0;
          done_d[gnt_q] = 1'b1;
          ptr_d         = gnt_q;
          state_d       = ACK;
        end
      end
      ACK: begin
        if (!bus.fifo_tx_done && !bus.req_rdy[gnt_q]) begin
          done_d  = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      gnt_q   <= '0;
      tx_q    <= 1'b0;
      dat_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      tx_q    <= tx_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.req_done     = done_q;
  assign bus.fifo_tx_rdy  = tx_q;
  assign bus.fifo_in_data = dat_q;
  assign bus.grant_id     = gnt_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_fifo_tx_arbiter.sv
// Directed bench for fifo_tx_arbiter: plays producers and fifo,
// checks grants, words, handshake timing and round-robin fairness.
module tb_fifo_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fifo_tx_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  fifo_tx_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    bus.req_rdy      = '0;
    bus.req_data     = '0;
    bus.fifo_tx_done = 1'b0;
    bus.fifo_full    = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic raise(input int id, input logic [7:0] w);
    bus.req_data[id*WIDTH +: WIDTH] = w;
    bus.req_rdy[id] = 1'b1;
  endtask

  // wait for grant, check it, ack after dly cycles, finish handshake
  task automatic xfer(input int id, input logic [7:0] w, input int dly);
    int   n;
    logic ok;
    n = 0;
    while (!bus.fifo_tx_rdy && n < 64) begin
      step();
      n++;
    end
    chk("tx_rdy_seen", 32'(bus.fifo_tx_rdy), 32'd1);
    chk("grant_id", 32'(bus.grant_id), 32'(id));
    chk("in_data", 32'(bus.fifo_in_data), 32'(w));
    ok = 1'b1;
    repeat (dly) begin
      step();
      if (!(bus.fifo_tx_rdy === 1'b1 && bus.fifo_in_data === w &&
            bus.req_done === '0 && bus.busy === 1'b1))
        ok = 1'b0;
    end
    chk("send_hold", 32'(ok), 32'd1);
    bus.fifo_tx_done = 1'b1;
    step();
    chk("req_done", 32'(bus.req_done), 32'(1 << id));
    chk("tx_rdy_low", 32'(bus.fifo_tx_rdy), 32'd0);
    bus.req_rdy[id]  = 1'b0;
    bus.fifo_tx_done = 1'b0;
    step();
    chk("done_clr", 32'(bus.req_done), 32'd0);
    chk("release_busy", 32'(bus.busy), 32'd1);
    step();
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] p, input int ptr);
    int r;
    r = -1;
    for (int i = 1; i <= NREQ; i++)
      if (r < 0 && p[(ptr + i) % NREQ]) r = (ptr + i) % NREQ;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]      word [NREQ];
    int              seq  [NREQ];
    int              waitc[NREQ];
    logic [NREQ-1:0] pend;
    int              ptr_m, issued, served, maxwait, e, n;
    logic            ok;

    // test 1: reset values, single request with 2-cycle fifo ack
    do_reset();
    chk("rst_tx_rdy", 32'(bus.fifo_tx_rdy), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.req_done), 32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd0);
    chk("rst_data", 32'(bus.fifo_in_data), 32'd0);
    raise(0, 8'hA5);
    step();
    chk("t1_latency", 32'(bus.fifo_tx_rdy), 32'd1);
    xfer(0, 8'hA5, 2);
    chk("t1_idle", 32'(bus.busy), 32'd0);

    // test 2: all four request, served in index order, then wrap to 0
    do_reset();
    raise(0, 8'h11);
    raise(1, 8'h22);
    raise(2, 8'h33);
    raise(3, 8'h44);
    xfer(0, 8'h11, 1);
    xfer(1, 8'h22, 1);
    xfer(2, 8'h33, 1);
    xfer(3, 8'h44, 1);
    raise(0, 8'h55);
    raise(2, 8'h66);
    xfer(0, 8'h55, 1);
    xfer(2, 8'h66, 1);

    // test 3: fifo full blocks the grant
    do_reset();
    bus.fifo_full = 1'b1;
    raise(2, 8'h3C);
    ok = 1'b1;
    repeat (20) begin
      step();
      if (bus.fifo_tx_rdy !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
    end
    chk("t3_full_hold", 32'(ok), 32'd1);
    bus.fifo_full = 1'b0;
    xfer(2, 8'h3C, 3);

    // test 4: after grant 3, requests 3 and 0 -> 0 first (wrap)
    do_reset();
    raise(3, 8'hD3);
    xfer(3, 8'hD3, 1);
    raise(0, 8'hE0);
    raise(3, 8'hE3);
    xfer(0, 8'hE0, 2);
    xfer(3, 8'hE3, 1);

    // test 5: async reset in the middle of SEND
    do_reset();
    raise(1, 8'h5A);
    step();
    chk("t5_send", 32'(bus.fifo_tx_rdy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_rdy", 32'(bus.fifo_tx_rdy), 32'd0);
    chk("t5_async_busy", 32'(bus.busy), 32'd0);
    chk("t5_async_done", 32'(bus.req_done), 32'd0);
    chk("t5_async_gnt", 32'(bus.grant_id), 32'd0);
    raise(0, 8'h0F);
    #1;
    rst_n = 1'b1;
    xfer(0, 8'h0F, 1);
    xfer(1, 8'h5A, 1);

    // test 6: random requests and ack delays against a round-robin model
    do_reset();
    pend    = '0;
    ptr_m   = NREQ - 1;
    issued  = 0;
    served  = 0;
    maxwait = 0;
    for (int k = 0; k < NREQ; k++) begin
      seq[k]   = 0;
      waitc[k] = 0;
      word[k]  = '0;
    end
    n = 0;
    while (n < 200 && (n < 60 || pend != '0)) begin
      if (n < 60) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!pend[k] && $urandom_range(0, 1) == 1) begin
            word[k] = {2'(k), 6'(seq[k])};
            seq[k]++;
            raise(k, word[k]);
            pend[k] = 1'b1;
            issued++;
          end
        end
        if (pend == '0) begin
          e       = n % NREQ;
          word[e] = {2'(e), 6'(seq[e])};
          seq[e]++;
          raise(e, word[e]);
          pend[e] = 1'b1;
          issued++;
        end
      end
      e = rr_pick(pend, ptr_m);
      xfer(e, word[e], int'($urandom_range(1, 5)));
      pend[e]  = 1'b0;
      ptr_m    = e;
      served++;
      waitc[e] = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (pend[k]) begin
          waitc[k]++;
          if (waitc[k] > maxwait) maxwait = waitc[k];
        end
      end
      n++;
    end
    chk("t6_served", 32'(served), 32'(issued));
    chk("t6_no_starve", 32'(maxwait <= NREQ - 1), 32'd1);
    chk("t6_idle", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
